// File: rtl/hazard_forward_unit.sv
// Load-use hazard detection and EX operand-forwarding control for a 5-stage core.
// A shadow pipeline tracks the EX/MEM/WB producers and feeds the forwarding muxes.
module hazard_forward_unit #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                ex_flush,
  output logic [1:0]          fwd_a_sel,
  output logic [1:0]          fwd_b_sel,
  output logic                stall,
  output logic [CNT_BITS-1:0] stall_count
);

  localparam logic [1:0]          SEL_IDEX = 2'b00;
  localparam logic [1:0]          SEL_WB   = 2'b01;
  localparam logic [1:0]          SEL_MEM  = 2'b10;
  localparam logic [REG_BITS-1:0] X0       = '0;
  localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

  logic [REG_BITS-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_BITS-1:0] ex_rs2_q, ex_rs2_d;
  logic [REG_BITS-1:0] ex_rd_q,  ex_rd_d;
  logic                ex_rw_q,  ex_rw_d;
  logic                ex_mr_q,  ex_mr_d;
  logic [REG_BITS-1:0] mem_rd_q, mem_rd_d;
  logic                mem_rw_q, mem_rw_d;
  logic [REG_BITS-1:0] wb_rd_q,  wb_rd_d;
  logic                wb_rw_q,  wb_rw_d;
  logic [CNT_BITS-1:0] stall_count_q, stall_count_d;
  logic                lu;
  logic                id_accept;

  // Handshake: id_valid qualifies all id_* fields; stall is the not-ready back
  // toward ID. An ID instruction enters EX on an edge where id_valid && !stall
  // && !ex_flush; otherwise EX takes a bubble and the front end re-presents it.
  always_comb begin
    lu        = ex_mr_q && (ex_rd_q != X0) && id_valid &&
                ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
    stall     = lu && !ex_flush;
    id_accept = id_valid && !stall && !ex_flush;
  end

  always_comb begin
    ex_rs1_d = '0;
    ex_rs2_d = '0;
    ex_rd_d  = '0;
    ex_rw_d  = 1'b0;
    ex_mr_d  = 1'b0;
    if (id_accept) begin
      ex_rs1_d = id_rs1;
      ex_rs2_d = id_rs2;
      ex_rd_d  = id_rd;
      ex_rw_d  = id_reg_write;
      ex_mr_d  = id_mem_read;
    end
    // The back end never holds: a stall only freezes PC and IF/ID.
    mem_rd_d = ex_rd_q;
    mem_rw_d = ex_rw_q;
    wb_rd_d  = mem_rd_q;
    wb_rw_d  = mem_rw_q;
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_rw_q       <= 1'b0;
      ex_mr_q       <= 1'b0;
      mem_rd_q      <= '0;
      mem_rw_q      <= 1'b0;
      wb_rd_q       <= '0;
      wb_rw_q       <= 1'b0;
      stall_count_q <= '0;
    end else begin
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_rw_q       <= ex_rw_d;
      ex_mr_q       <= ex_mr_d;
      mem_rd_q      <= mem_rd_d;
      mem_rw_q      <= mem_rw_d;
      wb_rd_q       <= wb_rd_d;
      wb_rw_q       <= wb_rw_d;
      stall_count_q <= stall_count_d;
    end
  end

  // MEM is checked first so the youngest producer wins; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_BITS-1:0] src,
    input logic [REG_BITS-1:0] m_rd,
    input logic                m_rw,
    input logic [REG_BITS-1:0] w_rd,
    input logic                w_rw
  );
    if (m_rw && (m_rd != X0) && (m_rd == src)) begin
      return SEL_MEM;
    end else if (w_rw && (w_rd != X0) && (w_rd == src)) begin
      return SEL_WB;
    end
    return SEL_IDEX;
  endfunction

  always_comb begin
    fwd_a_sel = fwd_sel(ex_rs1_q, mem_rd_q, mem_rw_q, wb_rd_q, wb_rw_q);
    fwd_b_sel = fwd_sel(ex_rs2_q, mem_rd_q, mem_rw_q, wb_rd_q, wb_rw_q);
  end

  assign stall_count = stall_count_q;

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Sequential hazard-detection and operand-forwarding controller for the 5-stage pipelined RISC-V core. It tracks the destination register, register-write and memory-read flags of the instructions in EX, MEM and WB using its own shadow pipeline. From that state it drives the `sel` inputs of the two EX-stage 3-to-1 operand multiplexers (`fwd_a_sel`, `fwd_b_sel`) and the load-use `stall` that holds PC and IF/ID. A saturating stall counter supports performance measurement.

## Interface

Parameters:
- `REG_BITS`, 5, register-index width.
- `CNT_BITS`, 32, stall-counter width.

Ports:
- `clk`, input, 1, single clock; all state updates on rising edge.
- `rst`, input, 1, asynchronous, active-high reset.
- `id_valid`, input, 1, the ID stage holds a real instruction.
- `id_rs1`, input, `REG_BITS`, ID source register 1.
- `id_rs2`, input, `REG_BITS`, ID source register 2.
- `id_rd`, input, `REG_BITS`, ID destination register.
- `id_reg_write`, input, 1, the ID instruction writes the register file.
- `id_mem_read`, input, 1, the ID instruction is a load.
- `ex_flush`, input, 1, taken branch or jump resolved in EX this cycle.
- `fwd_a_sel`, output, 2, EX operand-A mux select: 00 = ID/EX register value, 01 = WB result, 10 = MEM ALU result.
- `fwd_b_sel`, output, 2, EX operand-B mux select, same encoding.
- `stall`, output, 1, hold PC and IF/ID this cycle.
- `stall_count`, output, `CNT_BITS`, number of cycles in which `stall` was 1; saturates at the maximum value.

## Operation

- Shadow pipeline registers:
  - EX: `ex_rs1`, `ex_rs2`, `ex_rd`, `ex_rw`, `ex_mr`.
  - MEM: `mem_rd`, `mem_rw`.
  - WB: `wb_rd`, `wb_rw`.
- Bubble: all fields zero.
- EX load rule, each rising edge:
  - Load a bubble if `ex_flush`, `stall` or `!id_valid` is 1.
  - Otherwise load the `id_*` fields.
- MEM ← EX and WB ← MEM every cycle, with no hold. A stall only freezes the front end; the back end keeps draining.
- Forwarding, combinational from registered state only; no input-to-output path. `fwd_a_sel` is decided as follows, first match wins; `fwd_b_sel` is identical using `ex_rs2`:
  1. `mem_rw && mem_rd != 0 && mem_rd == ex_rs1` → 10.
  2. `wb_rw && wb_rd != 0 && wb_rd == ex_rs1` → 01.
  3. Otherwise → 00.
- MEM takes priority over WB when both match, so the youngest producer wins.
- x0 is never forwarded.
- Load-use detection:
  - `lu = ex_mr && ex_rd != 0 && id_valid && (ex_rd == id_rs1 || ex_rd == id_rs2)`.
  - `stall = lu && !ex_flush`.
- Flush takes priority over stall: the ID instruction is discarded, so it is not held.
- A stall lasts exactly one cycle per load-use pair. After the bubble enters EX, the load sits in MEM. The dependent instruction then reaches EX while the load is in WB and gets select 01.
- Loads do not forward from MEM. The MEM-stage ALU result for a load is the address; the stall guarantees no consumer is in EX at that point.
- `stall_count` increments by 1 on each edge where `stall` = 1, unless it is all-ones.

## Timing

- Reset (async, immediate on `rst` rising, held while `rst` = 1):
  - All shadow registers are zero (bubbles in EX, MEM and WB).
  - `fwd_a_sel` and `fwd_b_sel` = 00, `stall` = 0, `stall_count` = 0.
- First edge after `rst` falls: normal capture.
- Latency:
  - A producer in EX at cycle t appears as a MEM match at t+1 and a WB match at t+2. At t+3 it no longer affects selects.
  - `stall` is valid in the same cycle as the ID inputs (combinational path from `id_*` and `ex_flush`).
- Simultaneous cases:
  - `ex_flush` with `lu`: `stall` = 0, EX takes a bubble, counter unchanged.
  - `!id_valid` with matching regs: `stall` = 0.
- Reset mid-stall: `stall` drops asynchronously and pending bubbles are discarded.
- Counter saturation: it holds all-ones. With `CNT_BITS` = 4, the bench checks that 15 holds.

## Test plan

- **EX→EX chain.**
  - Stimulus: `add x5` (rd=5, rw=1), then `sub` with rs1=5 on the next cycle.
  - Response: the cycle `sub` is in EX, `fwd_a_sel` = 10 and `fwd_b_sel` = 00.
- **MEM and WB both match.**
  - Stimulus: rd=5 in two consecutive writers, then a reader with rs2=5.
  - Response: `fwd_b_sel` = 10 (MEM wins). When only the older writer matches, `fwd_b_sel` = 01.
- **x0 and no-write.**
  - Stimulus: a writer with rd=0 or rw=0, followed by a reader of that register.
  - Response: selects stay 00.
- **Load-use.**
  - Stimulus: `lw x7`, then `add` with rs1=7.
  - Response:
    - `stall` = 1 for exactly one cycle; EX receives a bubble; `stall_count` 0→1.
    - Next cycle: `stall` = 0. When the `add` is in EX, `fwd_a_sel` = 01.
- **Flush over stall.**
  - Stimulus: the load-use condition together with `ex_flush` = 1.
  - Response: `stall` = 0, EX bubble, `stall_count` unchanged.
- **Reset mid-operation, then saturation.**
  - Stimulus: assert `rst` during a stall.
  - Response: all outputs zero at once; a following reader gets 00.
  - Saturation stimulus: 20 load-use stalls with `CNT_BITS` = 4.
  - Saturation response: `stall_count` = 15.
